// File: rtl/rgb_led_pwm_fader_pkg.sv
// Shared types and default palette for the RGB LED PWM fader.
// Palette defaults are 8-bit values; the top rescales them to PWM_BITS.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        BLUE   = 2'd3
    } color_e;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_e;

    // {r,g,b}, red in the MSBs
    localparam logic [23:0] DEF_RED    = {8'd64, 8'd0,  8'd0};
    localparam logic [23:0] DEF_YELLOW = {8'd31, 8'd31, 8'd0};
    localparam logic [23:0] DEF_GREEN  = {8'd0,  8'd64, 8'd0};
    localparam logic [23:0] DEF_BLUE   = {8'd0,  8'd0,  8'd64};

endpackage

// File: rtl/rgb_led_pwm_fader_pwm_channel.sv
// One colour channel: current duty with jump/step update and registered PWM compare.
// With GLOBAL_DIM_EN defined the compare uses the duty shifted right by dim.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] target,
`ifdef GLOBAL_DIM_EN
    input  logic [2:0]          dim,
`endif
    input  logic                jump,
    input  logic                step,
    output logic                led,
    output logic                at_target,
    output logic                near_target
);

    logic [PWM_BITS-1:0] cur_duty_r;
    logic [PWM_BITS-1:0] cur_nxt_s;
    logic [PWM_BITS-1:0] cmp_duty_s;
    logic [PWM_BITS:0]   cur_w_s;
    logic [PWM_BITS:0]   tgt_w_s;
    logic                led_out_r;

    assign cur_w_s     = {1'b0, cur_duty_r};
    assign tgt_w_s     = {1'b0, target};
    assign at_target   = (cur_duty_r == target);
    // Widened so a one-step difference at the range ends does not wrap
    assign near_target = at_target
                      || ((cur_w_s + {{PWM_BITS{1'b0}}, 1'b1}) == tgt_w_s)
                      || ((tgt_w_s + {{PWM_BITS{1'b0}}, 1'b1}) == cur_w_s);

`ifdef GLOBAL_DIM_EN
    assign cmp_duty_s = cur_duty_r >> dim;
`else
    assign cmp_duty_s = cur_duty_r;
`endif

    // Next duty: jump straight to target or move one step toward it
    always_comb begin
        cur_nxt_s = cur_duty_r;
        if (jump) begin
            cur_nxt_s = target;
        end else if (step) begin
            if (cur_duty_r < target) begin
                cur_nxt_s = cur_duty_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
            end else if (cur_duty_r > target) begin
                cur_nxt_s = cur_duty_r - {{(PWM_BITS-1){1'b0}}, 1'b1};
            end else begin
                cur_nxt_s = cur_duty_r;
            end
        end else begin
            cur_nxt_s = cur_duty_r;
        end
    end

    // Duty register and registered comparator output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_duty_r <= '0;
            led_out_r  <= 1'b0;
        end else begin
            cur_duty_r <= cur_nxt_s;
            led_out_r  <= (pwm_cnt < cmp_duty_s);
        end
    end

    assign led = led_out_r;

endmodule

// File: rtl/rgb_led_pwm_fader.sv
// RGB LED driver with a writable 4-entry palette and optional smooth fading.
// Optional global dimming input is enabled by defining GLOBAL_DIM_EN.
module rgb_led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int CLK_DIV  = 64,
    parameter int FADE_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            color,
    input  logic                  fade_en,
    input  logic                  wr_en,
    input  logic [1:0]            wr_addr,
    input  logic [3*PWM_BITS-1:0] wr_data,
`ifdef GLOBAL_DIM_EN
    input  logic [2:0]            dim,
`endif
    output logic                  led_r,
    output logic                  led_g,
    output logic                  led_b,
    output logic                  busy
);

    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX  = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam logic [FADE_W-1:0]   FADE_MAX = FADE_W'(FADE_DIV - 1);

    // v * 2^(PWM_BITS-8), valid for PWM_BITS above or below 8
    function automatic logic [PWM_BITS-1:0] scale8(input logic [7:0] v);
        logic [PWM_BITS+7:0] wide;
        wide   = {{PWM_BITS{1'b0}}, v} << PWM_BITS;
        scale8 = wide[PWM_BITS+7:8];
    endfunction

    function automatic logic [3*PWM_BITS-1:0] scale_entry(input logic [23:0] e);
        scale_entry = {scale8(e[23:16]), scale8(e[15:8]), scale8(e[7:0])};
    endfunction

    logic [PRE_W-1:0]      prescaler_r;
    logic [PWM_BITS-1:0]   pwm_cnt_r;
    logic [FADE_W-1:0]     fade_cnt_r;
    logic [FADE_W-1:0]     fade_cnt_nxt_s;
    fade_state_e           state_r;
    fade_state_e           state_nxt_s;
    logic [3*PWM_BITS-1:0] palette_r [4];
    logic [3*PWM_BITS-1:0] target_s;
    logic                  tick_s;
    logic                  period_end_s;
    logic                  jump_s;
    logic                  step_s;
    logic [2:0]            at_s;
    logic [2:0]            near_s;
    logic                  all_at_s;
    logic                  all_near_s;

    assign tick_s       = (prescaler_r == PRE_MAX);
    assign period_end_s = tick_s && (pwm_cnt_r == CNT_MAX);
    assign target_s     = palette_r[color];
    assign all_at_s     = &at_s;
    assign all_near_s   = &near_s;
    assign busy         = !all_at_s;

    // Clock prescaler producing the PWM tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_r <= '0;
        end else if (tick_s) begin
            prescaler_r <= '0;
        end else begin
            prescaler_r <= prescaler_r + PRE_W'(1);
        end
    end

    // PWM counter, period of 2^PWM_BITS-1 ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= '0;
        end else if (tick_s) begin
            pwm_cnt_r <= (pwm_cnt_r == CNT_MAX) ? '0 : pwm_cnt_r + PWM_BITS'(1);
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Palette storage; reset restores the scaled defaults
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            palette_r[RED]    <= scale_entry(DEF_RED);
            palette_r[YELLOW] <= scale_entry(DEF_YELLOW);
            palette_r[GREEN]  <= scale_entry(DEF_GREEN);
            palette_r[BLUE]   <= scale_entry(DEF_BLUE);
        end else if (wr_en) begin
            palette_r[wr_addr] <= wr_data;
        end else begin
            palette_r <= palette_r;
        end
    end

    // Fade state and fade step divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fade_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            fade_cnt_r <= fade_cnt_nxt_s;
        end
    end

    // Next-state and jump/step decisions, all gated on period_end
    always_comb begin
        state_nxt_s    = state_r;
        fade_cnt_nxt_s = fade_cnt_r;
        jump_s         = 1'b0;
        step_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (period_end_s && !all_at_s) begin
                    if (fade_en) begin
                        state_nxt_s    = FADE;
                        fade_cnt_nxt_s = '0;
                    end else begin
                        jump_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FADE: begin
                if (!period_end_s) begin
                    state_nxt_s = FADE;
                end else if (!fade_en) begin
                    jump_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else if (fade_cnt_r == FADE_MAX) begin
                    fade_cnt_nxt_s = '0;
                    step_s         = 1'b1;
                    state_nxt_s    = all_near_s ? IDLE : FADE;
                end else begin
                    fade_cnt_nxt_s = fade_cnt_r + FADE_W'(1);
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                fade_cnt_nxt_s = '0;
            end
        endcase
    end

`ifdef GLOBAL_DIM_EN
    logic [2:0] dim_r;

    // Dim level only changes at a period boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dim_r <= 3'd0;
        end else if (period_end_s) begin
            dim_r <= dim;
        end else begin
            dim_r <= dim_r;
        end
    end
`endif

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_r (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt_r),
        .target(target_s[3*PWM_BITS-1:2*PWM_BITS]),
`ifdef GLOBAL_DIM_EN
        .dim(dim_r),
`endif
        .jump(jump_s), .step(step_s),
        .led(led_r), .at_target(at_s[2]), .near_target(near_s[2])
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_g (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt_r),
        .target(target_s[2*PWM_BITS-1:PWM_BITS]),
`ifdef GLOBAL_DIM_EN
        .dim(dim_r),
`endif
        .jump(jump_s), .step(step_s),
        .led(led_g), .at_target(at_s[1]), .near_target(near_s[1])
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch_b (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt_r),
        .target(target_s[PWM_BITS-1:0]),
`ifdef GLOBAL_DIM_EN
        .dim(dim_r),
`endif
        .jump(jump_s), .step(step_s),
        .led(led_b), .at_target(at_s[0]), .near_target(near_s[0])
    );

endmodule
